// File: rtl/fft_feed_pkg.sv
// Shared FFT feed constants and the frame arbiter state encoding.
// Also used by the FIFO wrapper and the capture channels.
package fft_feed_pkg;

  localparam int FFT_DATA_W    = 22;
  localparam int FFT_FRAME_LEN = 64;
  localparam int FFT_CNT_W     = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fft_frame_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or after ptr,
// wrapping around NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_any
);

  int w_idx;

  // Scan from the farthest offset down so the nearest request at/after ptr wins last.
  always_comb begin
    o_gnt_id = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx    = (int'(i_ptr) + k) % NUM_REQ;
      o_gnt_id = i_req[w_idx] ? ID_W'(w_idx) : o_gnt_id;
      o_any    = o_any | i_req[w_idx];
    end
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Grants the FFT feed FIFO write port to one source for a whole frame at a time,
// round-robin between frames, stalling on source gaps and on FIFO full.
module fft_frame_arbiter
  import fft_feed_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = FFT_DATA_W,
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int CNT_W     = FFT_CNT_W,
  parameter int ID_W      = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_fifo_wr_en,
  output logic [DATA_W-1:0]         o_fifo_din,
  input  logic                      i_fifo_full,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic [15:0]               o_frame_cnt
);

  if (FRAME_LEN != (2 ** CNT_W)) begin : g_bad_frame_len
    $error("fft_frame_arbiter: FRAME_LEN must equal 2**CNT_W");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((2 ** ID_W) < NUM_REQ)) begin : g_bad_num_req
    $error("fft_frame_arbiter: NUM_REQ out of range for ID_W");
  end

  state_e            r_state;
  state_e            w_state_nx;
  logic [CNT_W-1:0]  r_beat;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_busy;
  logic              r_frame_done;
  logic [15:0]       r_frame_cnt;
  logic [ID_W-1:0]   w_pick;
  logic              w_any;
  logic              w_in_burst;
  logic              w_wr_en;
  logic              w_last;
  logic [ID_W-1:0]   w_ptr_nx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req    (i_req_valid),
    .i_ptr    (r_rr_ptr),
    .o_gnt_id (w_pick),
    .o_any    (w_any)
  );

  assign w_in_burst = (r_state == ST_BURST);
  assign w_wr_en    = w_in_burst & i_req_valid[r_grant_id] & ~i_fifo_full;
  assign w_last     = w_wr_en & (r_beat == CNT_W'(FRAME_LEN - 1));
  assign w_ptr_nx   = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  assign o_fifo_wr_en = w_wr_en;
  assign o_fifo_din   = i_req_data[r_grant_id*DATA_W +: DATA_W];
  assign o_grant_id   = r_grant_id;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;

  // Only the granted source sees ready, and only while the FIFO has room.
  always_comb begin
    o_req_ready = '0;
    if (w_in_burst) begin
      o_req_ready[r_grant_id] = ~i_fifo_full;
    end else begin
      o_req_ready = '0;
    end
  end

  // Next-state: a frame ends only on the write of its last beat.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  w_state_nx = w_any  ? ST_BURST : ST_IDLE;
      ST_BURST: w_state_nx = w_last ? ST_IDLE  : ST_BURST;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // State, beat counter, grant, round-robin pointer and frame statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_state      <= w_state_nx;
      r_frame_done <= w_last;
      if ((r_state == ST_IDLE) && w_any) begin
        r_grant_id <= w_pick;
        r_busy     <= 1'b1;
        r_beat     <= '0;
      end else if (w_wr_en) begin
        // beat wraps to zero on the last write since FRAME_LEN == 2**CNT_W
        r_beat <= r_beat + CNT_W'(1);
        if (w_last) begin
          r_busy      <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_rr_ptr    <= w_ptr_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Scoreboard bench for fft_frame_arbiter: stimulus pushes expected writes/frames,
// a monitor pops and compares on every FIFO write and frame_done pulse.
module tb_fft_frame_arbiter;

  localparam int NR = 4;
  localparam int DW = 22;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic            fifo_full = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            frame_done;
  logic [15:0]     frame_cnt;

  fft_frame_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_fifo_wr_en (fifo_wr_en),
    .o_fifo_din   (fifo_din),
    .i_fifo_full  (fifo_full),
    .o_grant_id   (grant_id),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_wr[$];
  logic [31:0] exp_fr[$];
  int cnt[NR];
  int lim[NR];
  logic [NR-1:0] en = '0;
  int full_src = -1;
  int full_at = 0;
  int full_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tag(input int s, input int k);
    return 32'((s << 16) | k);
  endfunction

  task automatic push_frame(input int s, input int k0, input int fcnt);
    for (int k = 0; k < 64; k++) exp_wr.push_back(tag(s, k0 + k));
    exp_fr.push_back({16'(s), 16'(fcnt)});
  endtask

  // One cycle: drive inputs at negedge, then record which sources will be accepted.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (cnt[i] < lim[i]);
      req_data[i*DW +: DW] = DW'((i << 16) | cnt[i]);
    end
    if ((full_src >= 0) && (cnt[full_src] == full_at) && (full_left > 0)) begin
      fifo_full = 1'b1;
      full_left--;
    end else begin
      fifo_full = 1'b0;
    end
    #1;
    if (fifo_full && rst_n) begin
      chk("ready_while_full", 32'(req_ready), 32'd0);
      chk("wr_while_full", 32'(fifo_wr_en), 32'd0);
    end
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) cnt[i]++;
  endtask

  task automatic run_until_drained(input string name, input int budget);
    int n;
    n = 0;
    while (((exp_wr.size() != 0) || (exp_fr.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    total++;
    if ((exp_wr.size() != 0) || (exp_fr.size() != 0)) begin
      bad++;
      $display("FAIL %s_timeout: got %0d writes %0d frames pending, required 0 0",
               name, exp_wr.size(), exp_fr.size());
      exp_wr.delete();
      exp_fr.delete();
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = '0;
    full_src = -1;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      lim[i] = 0;
    end
    #1;
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every FIFO write and every frame_done pulse against the queues.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (fifo_wr_en) begin
          if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_unexpected: got write %0h, required no write", fifo_din);
          end else begin
            chk("wr_data", 32'(fifo_din), exp_wr.pop_front());
          end
        end
        if (frame_done) begin
          if (exp_fr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got frame_done grant=%0d, required none", grant_id);
          end else begin
            chk("frame_id_cnt", {16'(grant_id), frame_cnt}, exp_fr.pop_front());
          end
          chk("gap_no_write", 32'(fifo_wr_en), 32'd0);
          chk("gap_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin : stim
    // 1: single source
    do_reset();
    en = 4'b0010;
    lim[1] = 64;
    push_frame(1, 0, 1);
    tick();
    tick();
    chk("t1_grant", 32'(grant_id), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    run_until_drained("t1", 200);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);

    // 2: fairness, all sources always valid
    do_reset();
    en = 4'b1111;
    for (int i = 0; i < NR; i++) lim[i] = 128;
    for (int f = 0; f < 8; f++) push_frame(f % 4, (f / 4) * 64, f + 1);
    run_until_drained("t2", 700);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd8);

    // 3: backpressure for ten cycles starting at beat 10
    do_reset();
    en = 4'b1000;
    lim[3] = 64;
    full_src = 3;
    full_at = 10;
    full_left = 10;
    push_frame(3, 0, 1);
    run_until_drained("t3", 200);
    chk("t3_full_used", 32'(full_left), 32'd0);
    chk("t3_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);

    // 4: granted source stalls while another source waits
    do_reset();
    en = 4'b0100;
    lim[2] = 64;
    lim[0] = 64;
    push_frame(2, 0, 1);
    push_frame(0, 0, 2);
    tick();
    en = 4'b0101;
    for (int n = 0; (n < 100) && (cnt[2] < 20); n++) tick();
    chk("t4_reach_beat20", 32'(cnt[2]), 32'd20);
    en = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t4_grant_held", 32'(grant_id), 32'd2);
      chk("t4_src0_ready", 32'(req_ready[0]), 32'd0);
      chk("t4_no_write", 32'(fifo_wr_en), 32'd0);
    end
    en = 4'b0101;
    run_until_drained("t4", 300);

    // 5: reset in the middle of a frame
    do_reset();
    en = 4'b0010;
    lim[1] = 200;
    for (int k = 0; k < 30; k++) exp_wr.push_back(tag(1, k));
    for (int n = 0; (n < 100) && (cnt[1] < 30); n++) tick();
    chk("t5_reach_beat30", 32'(cnt[1]), 32'd30);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant_id), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_rst_wr", 32'(fifo_wr_en), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_beat", 32'(dut.r_beat), 32'd0);
    chk("t5_abandoned", 32'(exp_wr.size()), 32'd0);
    en = 4'b0011;
    lim[0] = 64;
    lim[1] = 94;
    push_frame(0, 0, 1);
    push_frame(1, 30, 2);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_new_grant", 32'(grant_id), 32'd0);
    run_until_drained("t5", 300);

    // 6: frame counter wrap
    do_reset();
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    #1;
    chk("t6_preload", 32'(frame_cnt), 32'h0000FFFF);
    en = 4'b0100;
    lim[2] = 64;
    push_frame(2, 0, 0);
    run_until_drained("t6", 200);
    chk("t6_wrapped", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
